fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin, packet-aware write arbiter that shares the write port of the dual-clock `fifo` (DSIZE/ASIZE) among NREQ requesters. It sits entirely in the write clock domain, with its outputs connected directly to the fifo `wdata`/`winc` and its input taken from `wfull`. Once a requester wins arbitration, it keeps the port until its `last` beat, so packets are never interleaved in the FIFO.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data width; matches fifo DSIZE
CNTW, 16, width of completed-packet counter

Ports:
aclk  input  1  write-domain clock (same clock as fifo wclk)
srst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE]
req_last  input  NREQ  beat is the final beat of its packet
req_ready  output  NREQ  beat accepted this cycle (one-hot or zero)
wfull  input  1  fifo full flag
winc  output  1  fifo write enable
wdata  output  DSIZE  fifo write data
grant  output  NREQ  current owner, one-hot; zero when the port is idle and nobody is selected
busy  output  1  high in LOCK state
pkt_cnt  output  CNTW  number of completed packets; wraps modulo 2^CNTW

Behaviour:
- Registered state:
  - `state` ∈ {IDLE, LOCK}
  - `owner` (index)
  - `ptr` (round-robin priority index)
  - `pkt_cnt`
- Reset (srst sampled high at a rising aclk edge):
  - state=IDLE, ptr=0, owner=0, pkt_cnt=0.
  - While srst is high, the combinational outputs are forced: winc=0, req_ready=0, grant=0, busy=0, wdata=0.
- Selection (combinational, zero latency):
  - IDLE: sel = first i with req_valid[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. If no requester is valid: grant=0, winc=0, wdata=0.
  - LOCK: sel = owner, regardless of the other requesters' valids.
- Output equations:
  - grant = onehot(sel).
  - wdata = req_data[sel].
  - xfer = req_valid[sel] & ~wfull.
  - winc = xfer.
  - req_ready[sel] = ~wfull; every other req_ready bit = 0.
- Handshake rule: a beat transfers when req_valid[i] & req_ready[i]. A requester holds valid, data and last stable until the beat is accepted.
- Transitions on each aclk edge:
  - IDLE, xfer, last=0 → LOCK, owner<=sel.
  - IDLE, xfer, last=1 → stay IDLE; ptr<=(sel+1) mod NREQ; pkt_cnt+1.
  - LOCK, xfer, last=1 → IDLE; ptr<=(owner+1) mod NREQ; pkt_cnt+1.
  - LOCK, no xfer, or xfer with last=0 → stay LOCK.
  - IDLE, no xfer → no register changes.
- busy = (state==LOCK).
- wfull high: no transfer and no state, ptr or pkt_cnt change. The owner keeps the lock through the full period. A full FIFO never breaks a packet.
- Owner drops valid mid-packet: the port stalls with winc=0. No other requester is served until the owner's last beat transfers.
- Single-beat packets (last=1 on the first beat) never enter LOCK.
- Beat throughput: one beat per cycle maximum. A back-to-back new packet from a different requester may start in the cycle right after a last beat.
- srst mid-packet: state returns to IDLE and ptr to 0. The partial packet already in the FIFO is not removed; fifo-side flushing is the system's responsibility.
- ptr arithmetic wraps at NREQ, which need not be a power of 2.

Test Plan:
- Reset and idle:
  - Stimulus: srst=1 for 3 cycles with all req_valid=1.
  - Required: winc=0, req_ready=0, grant=0, pkt_cnt=0.
  - Stimulus: after release, all valid with last=1.
  - Required: grants cycle 0,1,2,3,0,… one per cycle; pkt_cnt=8 after 8 cycles.
- Packet lock:
  - Stimulus: req0 sends 4 beats 0xA0..0xA3 (last on 0xA3) while req1 valid continuously.
  - Required: wdata sequence A0,A1,A2,A3 with no req1 beat in between; busy=1 for cycles 1-3; req1 is granted in the next cycle.
- Backpressure:
  - Stimulus: wfull=1 for 5 cycles in the middle of a req2 packet, with req3 valid.
  - Required: winc=0 and grant stays req2 for all 5 cycles; the packet resumes intact after wfull drops; req3 is served only after req2's last beat.
- Owner stall:
  - Stimulus: req1 deasserts valid for 3 cycles after beat 2 of a 5-beat packet.
  - Required: winc=0 for those 3 cycles, busy=1, no other grant.
- Fairness and wrap:
  - Stimulus: NREQ=3 instance, ptr=2, req0 and req2 valid.
  - Required: req2 is served first; ptr becomes 0 after its packet completes.
- Reset mid-packet:
  - Stimulus: srst asserted during beat 2 of a req3 packet.
  - Required: next cycle after release state=IDLE, ptr=0, and the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Packet-aware round-robin arbiter sharing one FIFO write port
//            among NREQ requesters; a winner holds the port until its last beat.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic                   aclk,
    input  logic                   srst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   wfull,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic [CNTW-1:0]        pkt_cnt
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NREQ - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_LOCK = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_owner;
    logic [c_IDX_W-1:0] w_owner_nxt;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_ptr_nxt;
    logic [CNTW-1:0]    r_pkt_cnt;
    logic [CNTW-1:0]    w_pkt_cnt_nxt;

    logic               w_rr_found;
    logic [c_IDX_W-1:0] w_rr_sel;
    int                 w_idx;

    logic [c_IDX_W-1:0] w_sel;
    logic               w_active;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_xfer;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_ready;
    logic [DSIZE-1:0]   w_wdata;

    // Rotating search starting at r_ptr; the index wraps at NREQ, which need
    // not be a power of two, so one conditional subtract replaces a modulo.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sel   = '0;
        w_idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_rr_found && req_valid[c_IDX_W'(w_idx)]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = c_IDX_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_sel       = (r_state == c_ST_LOCK) ? r_owner : w_rr_sel;
        w_active    = ((r_state == c_ST_LOCK) || w_rr_found) && !srst;
        w_grant     = '0;
        w_ready     = '0;
        w_wdata     = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_active && (w_sel == c_IDX_W'(i))) begin
                w_grant[i]  = 1'b1;
                w_ready[i]  = ~wfull;
                w_wdata     = req_data[i*DSIZE +: DSIZE];
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
            end
        end
        w_xfer = w_sel_valid & ~wfull;
    end

    // A stalled or backpressured owner keeps the lock; only its last beat
    // releases the port and advances the priority pointer.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_pkt_cnt_nxt = r_pkt_cnt;
        if (w_xfer) begin
            if (w_sel_last) begin
                w_state_nxt   = c_ST_IDLE;
                w_ptr_nxt     = (w_sel == c_LAST_IDX) ? '0 : w_sel + c_IDX_W'(1);
                w_pkt_cnt_nxt = r_pkt_cnt + CNTW'(1);
            end else begin
                w_state_nxt = c_ST_LOCK;
                w_owner_nxt = w_sel;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state   <= c_ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
        end
    end

    assign grant     = w_grant;
    assign req_ready = w_ready;
    assign wdata     = w_wdata;
    assign winc      = w_xfer;
    assign busy      = (r_state == c_ST_LOCK) && !srst;
    assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Randomized bench for fifo_wr_arbiter (NREQ=4 and NREQ=3 copies)
//            against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic srst;
    logic wfull;

    logic [3:0]  rv0, rl0, rr0, gr0;
    logic [31:0] rd0;
    logic [7:0]  wd0;
    logic        winc0, busy0;
    logic [15:0] pc0;

    logic [2:0]  rv1, rl1, rr1, gr1;
    logic [23:0] rd1;
    logic [7:0]  wd1;
    logic        winc1, busy1;
    logic [15:0] pc1;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .CNTW(16)) u_dut4 (
        .aclk(aclk), .srst(srst), .req_valid(rv0), .req_data(rd0), .req_last(rl0),
        .req_ready(rr0), .wfull(wfull), .winc(winc0), .wdata(wd0), .grant(gr0),
        .busy(busy0), .pkt_cnt(pc0));

    fifo_wr_arbiter #(.NREQ(3), .DSIZE(8), .CNTW(16)) u_dut3 (
        .aclk(aclk), .srst(srst), .req_valid(rv1), .req_data(rd1), .req_last(rl1),
        .req_ready(rr1), .wfull(wfull), .winc(winc1), .wdata(wd1), .grant(gr1),
        .busy(busy1), .pkt_cnt(pc1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-instance lock flag, owner, priority pointer, count.
    int         nq[2] = '{4, 3};
    bit         m_lock[2];
    int         m_owner[2];
    int         m_ptr[2];
    logic [15:0] m_cnt[2];

    // Requester packet generators.
    bit         g_valid[2][8];
    logic [7:0] g_data[2][8];
    bit         g_last[2][8];
    int         g_rem[2][8];

    logic [7:0] e_grant[2];
    logic [7:0] e_ready[2];
    logic [7:0] e_wdata[2];
    bit         e_winc[2];
    bit         e_busy[2];
    int         e_sel[2];

    task automatic model_eval(input int d);
        int sel = -1;
        int n   = nq[d];
        if (m_lock[d]) begin
            sel = m_owner[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                int i = (m_ptr[d] + k) % n;
                if (sel < 0 && g_valid[d][i]) sel = i;
            end
        end
        e_sel[d]   = sel;
        e_grant[d] = 8'h00;
        e_ready[d] = 8'h00;
        e_wdata[d] = 8'h00;
        e_winc[d]  = 1'b0;
        if (!srst && sel >= 0) begin
            e_grant[d] = 8'(1 << sel);
            e_wdata[d] = g_data[d][sel];
            e_winc[d]  = g_valid[d][sel] && !wfull;
            e_ready[d] = wfull ? 8'h00 : 8'(1 << sel);
        end
        e_busy[d] = !srst && m_lock[d];
    endtask

    task automatic model_clock(input int d);
        int sel = e_sel[d];
        if (srst) begin
            m_lock[d]  = 1'b0;
            m_owner[d] = 0;
            m_ptr[d]   = 0;
            m_cnt[d]   = 16'd0;
        end else if (e_winc[d]) begin
            if (g_last[d][sel]) begin
                m_lock[d] = 1'b0;
                m_ptr[d]  = (sel + 1) % nq[d];
                m_cnt[d]  = m_cnt[d] + 16'd1;
            end else begin
                m_lock[d]  = 1'b1;
                m_owner[d] = sel;
            end
        end
        for (int r = 0; r < nq[d]; r++) begin
            if (g_valid[d][r] && e_ready[d][r]) begin
                g_valid[d][r] = 1'b0;
                if (g_rem[d][r] > 0) g_rem[d][r]--;
            end
        end
    endtask

    // mode 0: every requester offers single-beat packets; mode 1: random packets
    // of 1..5 beats with random valid gaps. Valid beats stay stable until accepted.
    task automatic gen_drive(input int d, input int mode);
        for (int r = 0; r < nq[d]; r++) begin
            if (!g_valid[d][r]) begin
                if (mode == 0) begin
                    g_rem[d][r]   = 1;
                    g_valid[d][r] = 1'b1;
                    g_last[d][r]  = 1'b1;
                    g_data[d][r]  = 8'($urandom);
                end else begin
                    if (g_rem[d][r] == 0 && $urandom_range(0, 3) == 0)
                        g_rem[d][r] = $urandom_range(1, 5);
                    if (g_rem[d][r] > 0 && $urandom_range(0, 9) < 7) begin
                        g_valid[d][r] = 1'b1;
                        g_data[d][r]  = 8'($urandom);
                        g_last[d][r]  = (g_rem[d][r] == 1);
                    end
                end
            end
        end
    endtask

    task automatic pack_inputs();
        for (int r = 0; r < 4; r++) begin
            rv0[r]          = g_valid[0][r];
            rl0[r]          = g_last[0][r];
            rd0[r*8 +: 8]   = g_data[0][r];
        end
        for (int r = 0; r < 3; r++) begin
            rv1[r]          = g_valid[1][r];
            rl1[r]          = g_last[1][r];
            rd1[r*8 +: 8]   = g_data[1][r];
        end
    endtask

    initial begin
        int wf_left = 0;
        srst  = 1'b1;
        wfull = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_lock[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 16'd0;
            for (int r = 0; r < 8; r++) begin
                g_valid[d][r] = 1'b0; g_data[d][r] = 8'h00;
                g_last[d][r] = 1'b0;  g_rem[d][r] = 0;
            end
        end
        pack_inputs();
        @(posedge aclk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge aclk);
            srst = (cyc < 3) || (cyc > 20 && $urandom_range(0, 199) == 0);
            if (cyc < 11) begin
                wfull = 1'b0;
            end else if (wf_left > 0) begin
                wfull = 1'b1;
                wf_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                wfull   = 1'b1;
                wf_left = $urandom_range(0, 5);
            end else begin
                wfull = 1'b0;
            end
            for (int d = 0; d < 2; d++) gen_drive(d, (cyc < 11) ? 0 : 1);
            pack_inputs();
            #1;
            for (int d = 0; d < 2; d++) model_eval(d);

            check_val($sformatf("n4 grant c%0d", cyc), 64'(gr0),   64'(e_grant[0]));
            check_val($sformatf("n4 ready c%0d", cyc), 64'(rr0),   64'(e_ready[0]));
            check_val($sformatf("n4 winc c%0d", cyc),  64'(winc0), 64'(e_winc[0]));
            check_val($sformatf("n4 wdata c%0d", cyc), 64'(wd0),   64'(e_wdata[0]));
            check_val($sformatf("n4 busy c%0d", cyc),  64'(busy0), 64'(e_busy[0]));
            check_val($sformatf("n4 pktcnt c%0d", cyc), 64'(pc0),  64'(m_cnt[0]));
            check_val($sformatf("n3 grant c%0d", cyc), 64'(gr1),   64'(e_grant[1]));
            check_val($sformatf("n3 ready c%0d", cyc), 64'(rr1),   64'(e_ready[1]));
            check_val($sformatf("n3 winc c%0d", cyc),  64'(winc1), 64'(e_winc[1]));
            check_val($sformatf("n3 wdata c%0d", cyc), 64'(wd1),   64'(e_wdata[1]));
            check_val($sformatf("n3 busy c%0d", cyc),  64'(busy1), 64'(e_busy[1]));
            check_val($sformatf("n3 pktcnt c%0d", cyc), 64'(pc1),  64'(m_cnt[1]));

            // Opening sequence: all requesters valid with single-beat packets.
            if (cyc >= 3 && cyc < 11) begin
                check_val($sformatf("n4 rr_seq c%0d", cyc), 64'(gr0), 64'(1 << ((cyc - 3) % 4)));
                check_val($sformatf("n3 rr_seq c%0d", cyc), 64'(gr1), 64'(1 << ((cyc - 3) % 3)));
            end
            if (cyc == 11) begin
                check_val("n4 pktcnt_after8", 64'(pc0), 64'd8);
                check_val("n3 pktcnt_after8", 64'(pc1), 64'd8);
            end

            @(posedge aclk);
            for (int d = 0; d < 2; d++) model_clock(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
